// File: rtl/game_pkg.sv
// Shared encodings for the ball-and-paddle match controller.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_AI0 = 2'b00;
    localparam logic [1:0] MODE_AI1 = 2'b01;
    localparam logic [1:0] MODE_AI2 = 2'b10;
    localparam logic [1:0] MODE_PVP = 2'b11;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b01;
    localparam logic [1:0] WIN_RIGHT = 2'b10;

    localparam int unsigned CNT_W = 8;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/frame_delay.sv
// Tick-qualified delay counter; o_done flags the tick that reaches i_target.
module frame_delay
    import game_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;

    assign w_count_next = r_count + CNT_W'(1);
    assign o_done       = i_tick && (w_count_next == i_target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_tick) begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Match controller: sequences idle/serve/play/point/over, keeps scores and
// drives the enable, turn and difficulty controls of the game datapath.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned SERVE_DELAY = 60,
    parameter int unsigned POINT_HOLD  = 90,
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned HARD_HITS   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start_btn,
    input  logic [1:0] mode,
    input  logic       hit,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       start_state,
    output logic       ball_en,
    output logic       ai_en,
    output logic       turn,
    output logic       hard_mode,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    state_t           r_state;
    logic             r_start_prev;
    logic             r_serve_dir;
    logic [4:0]       r_rally;
    logic             r_start_state;
    logic             r_ball_en;
    logic             r_ai_en;
    logic             r_turn;
    logic             r_hard_mode;
    logic [3:0]       r_score_l;
    logic [3:0]       r_score_r;
    logic [1:0]       r_winner;

    logic             w_start_edge;
    logic             w_timing;
    logic             w_done;
    logic             w_clr;
    logic [CNT_W-1:0] w_target;
    logic [4:0]       w_rally_next;
    logic             w_ai_mode;

    assign w_start_edge = start_btn & ~r_start_prev;
    assign w_ai_mode    = (mode != MODE_PVP);
    assign w_rally_next = (hit && r_rally != 5'd31) ? r_rally + 5'd1 : r_rally;

    // One counter serves both timed phases; clearing on done also covers POINT->SERVE.
    assign w_timing = (r_state == SERVE) || (r_state == POINT);
    assign w_clr    = !w_timing || w_done;
    assign w_target = (r_state == SERVE) ? CNT_W'(SERVE_DELAY) : CNT_W'(POINT_HOLD);

    frame_delay u_delay (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clr),
        .i_tick   (tick),
        .i_target (w_target),
        .o_done   (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_start_prev  <= 1'b0;
            r_serve_dir   <= 1'b1;
            r_rally       <= '0;
            r_start_state <= 1'b1;
            r_ball_en     <= 1'b0;
            r_ai_en       <= 1'b0;
            r_turn        <= 1'b0;
            r_hard_mode   <= 1'b0;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_winner      <= WIN_NONE;
        end else begin
            r_start_prev <= start_btn;
            case (r_state)
                IDLE, OVER: begin
                    r_start_state <= 1'b1;
                    r_ball_en     <= 1'b0;
                    r_ai_en       <= 1'b0;
                    if (w_start_edge) begin
                        r_state     <= SERVE;
                        r_score_l   <= '0;
                        r_score_r   <= '0;
                        r_winner    <= WIN_NONE;
                        r_rally     <= '0;
                        r_serve_dir <= 1'b1;
                        r_turn      <= 1'b1;
                        r_hard_mode <= 1'b0;
                    end
                end
                SERVE: begin
                    r_turn      <= r_serve_dir;
                    r_rally     <= '0;
                    r_hard_mode <= 1'b0;
                    if (w_done) begin
                        r_state       <= PLAY;
                        r_start_state <= 1'b0;
                        r_ball_en     <= 1'b1;
                        r_ai_en       <= w_ai_mode;
                    end else begin
                        r_start_state <= 1'b1;
                        r_ball_en     <= 1'b0;
                        r_ai_en       <= 1'b0;
                    end
                end
                PLAY: begin
                    r_start_state <= 1'b0;
                    // A miss ends the rally before any same-cycle hit is counted.
                    if (miss_l || miss_r) begin
                        r_state   <= POINT;
                        r_ball_en <= 1'b0;
                        r_ai_en   <= 1'b0;
                        if (miss_l && !miss_r) begin
                            r_score_r   <= sat_inc4(r_score_r);
                            r_serve_dir <= 1'b0;
                        end else if (miss_r && !miss_l) begin
                            r_score_l   <= sat_inc4(r_score_l);
                            r_serve_dir <= 1'b1;
                        end
                    end else begin
                        r_ball_en   <= 1'b1;
                        r_ai_en     <= w_ai_mode;
                        r_rally     <= w_rally_next;
                        r_hard_mode <= (w_rally_next >= 5'(HARD_HITS)) && w_ai_mode;
                        if (hit) begin
                            r_turn <= ~r_turn;
                        end
                    end
                end
                POINT: begin
                    r_ball_en <= 1'b0;
                    r_ai_en   <= 1'b0;
                    if (w_done) begin
                        r_start_state <= 1'b1;
                        if (r_score_l == 4'(WIN_SCORE)) begin
                            r_winner <= WIN_LEFT;
                            r_state  <= OVER;
                        end else if (r_score_r == 4'(WIN_SCORE)) begin
                            r_winner <= WIN_RIGHT;
                            r_state  <= OVER;
                        end else begin
                            r_state     <= SERVE;
                            r_turn      <= r_serve_dir;
                            r_rally     <= '0;
                            r_hard_mode <= 1'b0;
                        end
                    end else begin
                        r_start_state <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign start_state = r_start_state;
    assign ball_en     = r_ball_en;
    assign ai_en       = r_ai_en;
    assign turn        = r_turn;
    assign hard_mode   = r_hard_mode;
    assign score_l     = r_score_l;
    assign score_r     = r_score_r;
    assign winner      = r_winner;
    assign state_o     = r_state;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with hand-computed expectations.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       start_btn;
    logic [1:0] mode;
    logic       hit;
    logic       miss_l;
    logic       miss_r;
    logic       start_state;
    logic       ball_en;
    logic       ai_en;
    logic       turn;
    logic       hard_mode;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [1:0] winner;
    logic [2:0] state_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    game_sequencer #(
        .SERVE_DELAY (60),
        .POINT_HOLD  (90),
        .WIN_SCORE   (7),
        .HARD_HITS   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .start_btn   (start_btn),
        .mode        (mode),
        .hit         (hit),
        .miss_l      (miss_l),
        .miss_r      (miss_r),
        .start_state (start_state),
        .ball_en     (ball_en),
        .ai_en       (ai_en),
        .turn        (turn),
        .hard_mode   (hard_mode),
        .score_l     (score_l),
        .score_r     (score_r),
        .winner      (winner),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    task automatic pulse_hit();
        @(negedge clk) hit = 1'b1;
        @(negedge clk) hit = 1'b0;
    endtask

    task automatic pulse_miss(input logic l, input logic r);
        @(negedge clk) begin miss_l = l; miss_r = r; end
        @(negedge clk) begin miss_l = 1'b0; miss_r = 1'b0; end
    endtask

    task automatic press_start();
        @(negedge clk) start_btn = 1'b1;
        @(negedge clk) start_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; start_btn = 1'b0; mode = 2'b00;
        hit = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 8'(state_o), 8'd0);
        chk("rst_start_state", 8'(start_state), 8'd1);
        chk("rst_ball_en", 8'(ball_en), 8'd0);
        chk("rst_ai_en", 8'(ai_en), 8'd0);
        chk("rst_turn", 8'(turn), 8'd0);
        chk("rst_hard", 8'(hard_mode), 8'd0);
        chk("rst_scores", {score_l, score_r}, 8'h00);
        chk("rst_winner", 8'(winner), 8'd0);
        rst = 1'b0;

        // Start edge: IDLE -> SERVE, button held high afterwards
        @(negedge clk) start_btn = 1'b1;
        @(negedge clk);
        chk("serve_state", 8'(state_o), 8'd1);
        chk("serve_turn", 8'(turn), 8'd1);
        ticks(59);
        chk("serve_59", 8'(state_o), 8'd1);
        chk("serve_59_ball", 8'(ball_en), 8'd0);
        ticks(1);
        chk("play_state", 8'(state_o), 8'd2);
        chk("play_ball_en", 8'(ball_en), 8'd1);
        chk("play_ai_en", 8'(ai_en), 8'd1);
        chk("play_turn", 8'(turn), 8'd1);
        chk("play_start_state", 8'(start_state), 8'd0);

        // A new start edge during PLAY is ignored
        @(negedge clk) start_btn = 1'b0;
        press_start();
        chk("play_ign_start", 8'(state_o), 8'd2);

        for (int i = 0; i < 7; i++) pulse_hit();
        chk("hit7_turn", 8'(turn), 8'd0);
        chk("hit7_hard", 8'(hard_mode), 8'd0);
        pulse_hit();
        chk("hit8_turn", 8'(turn), 8'd1);
        chk("hit8_hard", 8'(hard_mode), 8'd1);

        // Mode change mid-rally
        @(negedge clk) mode = 2'b11;
        @(negedge clk);
        chk("pvp_ai_en", 8'(ai_en), 8'd0);
        chk("pvp_hard", 8'(hard_mode), 8'd0);
        @(negedge clk) mode = 2'b00;
        @(negedge clk);
        chk("ai_back_ai_en", 8'(ai_en), 8'd1);
        chk("ai_back_hard", 8'(hard_mode), 8'd1);

        // miss_l: right scores, left serves next
        pulse_miss(1'b1, 1'b0);
        chk("missl_state", 8'(state_o), 8'd3);
        chk("missl_scores", {score_l, score_r}, 8'h01);
        chk("missl_ball_en", 8'(ball_en), 8'd0);
        chk("missl_ai_en", 8'(ai_en), 8'd0);
        chk("missl_hard_hold", 8'(hard_mode), 8'd1);
        ticks(89);
        chk("point_89", 8'(state_o), 8'd3);
        ticks(1);
        chk("point_done_state", 8'(state_o), 8'd1);
        chk("point_done_turn", 8'(turn), 8'd0);
        chk("point_done_hard", 8'(hard_mode), 8'd0);

        // Two-player rally: hard_mode never asserts
        @(negedge clk) mode = 2'b11;
        ticks(60);
        chk("pvp_play_state", 8'(state_o), 8'd2);
        chk("pvp_play_ai", 8'(ai_en), 8'd0);
        chk("pvp_play_turn", 8'(turn), 8'd0);
        for (int i = 0; i < 8; i++) pulse_hit();
        chk("pvp_hit8_hard", 8'(hard_mode), 8'd0);
        chk("pvp_hit8_turn", 8'(turn), 8'd0);

        // Simultaneous double miss plus hit
        @(negedge clk) begin miss_l = 1'b1; miss_r = 1'b1; hit = 1'b1; end
        @(negedge clk) begin miss_l = 1'b0; miss_r = 1'b0; hit = 1'b0; end
        chk("dbl_state", 8'(state_o), 8'd3);
        chk("dbl_scores", {score_l, score_r}, 8'h01);
        chk("dbl_turn", 8'(turn), 8'd0);
        ticks(90);
        chk("dbl_serve_turn", 8'(turn), 8'd0);

        // Seven right-edge misses: left wins 7:1
        for (int i = 0; i < 7; i++) begin
            ticks(60);
            pulse_miss(1'b0, 1'b1);
            chk("win_score_l", 8'(score_l), 8'(i + 1));
            ticks(90);
            chk("win_state", 8'(state_o), (i < 6) ? 8'd1 : 8'd4);
        end
        chk("over_winner", 8'(winner), 8'd1);
        chk("over_scores", {score_l, score_r}, 8'h71);
        chk("over_start_state", 8'(start_state), 8'd1);
        ticks(5);
        chk("over_hold", 8'(state_o), 8'd4);
        press_start();
        chk("restart_state", 8'(state_o), 8'd1);
        chk("restart_scores", {score_l, score_r}, 8'h00);
        chk("restart_winner", 8'(winner), 8'd0);
        chk("restart_turn", 8'(turn), 8'd1);

        // Build a 3:2 score, then reset mid-rally
        for (int i = 0; i < 5; i++) begin
            ticks(60);
            pulse_miss(i >= 3, i < 3);
            ticks(90);
        end
        ticks(60);
        pulse_hit();
        chk("pre_rst_state", 8'(state_o), 8'd2);
        chk("pre_rst_scores", {score_l, score_r}, 8'h32);
        chk("pre_rst_turn", 8'(turn), 8'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_state", 8'(state_o), 8'd0);
        chk("async_rst_scores", {score_l, score_r}, 8'h00);
        chk("async_rst_ctrl", {4'd0, start_state, ball_en, ai_en, turn}, 8'h08);
        chk("async_rst_hard", 8'(hard_mode), 8'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 8'(state_o), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
